// File: rtl/lc4_divider_iter_pkg.sv
// Shared definitions for the LC4 iterative divider.
//   - FSM state encodings (kept as plain 2-bit constants for legacy compatibility)
//   - Datapath width / iteration count
//   - Divide-by-zero result values
//   - Helper to rebuild the carry-out of the trial subtract from cla16's sum bit
package lc4_divider_iter_pkg;

    localparam int unsigned DIV_W     = 16;
    localparam int unsigned DIV_ITERS = 16;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 16'h0000;
    localparam logic [DIV_W-1:0] DIV_ZERO_R = 16'h0000;

    // cla16 exposes only the sum. The carry into bit 15 is recovered as
    // sum15 ^ a15 ^ b15, then the carry out is g15 | p15 & c15.
    function automatic logic sub_carry_out(input logic a15, input logic b15, input logic sum15);
        logic c15;
        c15 = sum15 ^ a15 ^ b15;
        return (a15 & b15) | ((a15 | b15) & c15);
    endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder (existing block, used unmodified).
//   a, b : 16-bit addends
//   cin  : carry in
//   sum  : a + b + cin (carry out not exposed)
// Four 4-bit groups; group generate/propagate give the group carries, bits ripple
// inside each group.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  gg;
    logic [2:0]  gp;
    logic [3:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = cin;
        // Only the lower three groups feed a further group carry.
        for (int j = 0; j < 3; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
                gp[j] = gp[j] & p[4*j+i];
            end
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < 4; j++) begin
            c[4*j] = gc[j];
            for (int i = 1; i < 4; i++) begin
                c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
            end
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/lc4_divider_iter.sv
// Multi-cycle unsigned 16-bit restoring divider for the LC4 ALU DIV/MOD ops.
// One quotient bit per clock; the trial subtract uses a single cla16 (a + ~b + 1).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_start       : request, operands sampled when accepted in IDLE
//   i_dividend    : unsigned dividend
//   i_divisor     : unsigned divisor
//   i_flush       : synchronous abort; wins over i_start
//   o_busy        : high in RUN and DONE
//   o_valid       : one-cycle result pulse (the DONE state)
//   o_quotient    : registered quotient, held until the next completion
//   o_remainder   : registered remainder, held until the next completion
module lc4_divider_iter
    import lc4_divider_iter_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    input  logic         i_flush,
    output logic         o_busy,
    output logic         o_valid,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    if (W != DIV_W) begin : g_bad_width
        $error("lc4_divider_iter: only W=16 is supported (cla16 subtractor)");
    end

    logic [1:0]   state_q, state_d;
    logic [3:0]   count_q;
    logic [W-1:0] rem_q, quo_q, dvd_q, dvs_q;

    logic [W-1:0] s, dvs_n, diff, rem_next, quo_next;
    logic         ge, accept, last_iter;

    // Shift the next dividend bit into the partial remainder; rem_q[15] is the
    // 17th bit of that shifted value and forces ge when set.
    assign s     = {rem_q[W-2:0], dvd_q[W-1]};
    assign dvs_n = ~dvs_q;

    cla16 u_sub (
        .a   (s),
        .b   (dvs_n),
        .cin (1'b1),
        .sum (diff)
    );

    assign ge       = rem_q[W-1] | sub_carry_out(s[W-1], dvs_n[W-1], diff[W-1]);
    assign rem_next = ge ? diff : s;
    assign quo_next = {quo_q[W-2:0], ge};

    assign accept    = (state_q == DIV_IDLE) && i_start && !i_flush;
    assign last_iter = (state_q == DIV_RUN) && (count_q == 4'(DIV_ITERS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: if (accept) state_d = DIV_RUN;
            DIV_RUN: begin
                if (i_flush)        state_d = DIV_IDLE;
                else if (last_iter) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dvd_q   <= i_dividend;
                dvs_q   <= i_divisor;
                rem_q   <= '0;
                quo_q   <= '0;
                count_q <= '0;
            end else if (state_q == DIV_RUN && !i_flush) begin
                rem_q   <= rem_next;
                quo_q   <= quo_next;
                dvd_q   <= {dvd_q[W-2:0], 1'b0};
                count_q <= count_q + 4'd1;
                if (last_iter) begin
                    // Divide by zero still runs the full latency, then reports 0/0.
                    o_quotient  <= (dvs_q == '0) ? DIV_ZERO_Q : quo_next;
                    o_remainder <= (dvs_q == '0) ? DIV_ZERO_R : rem_next;
                end
            end
        end
    end

    // DONE is only entered without a flush, so the state decode is the valid pulse.
    assign o_busy  = (state_q != DIV_IDLE);
    assign o_valid = (state_q == DIV_DONE);

endmodule

// File: tb/tb_lc4_divider_iter.sv
module tb_lc4_divider_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_dividend = '0;
    logic [15:0] i_divisor = '0;
    logic        i_flush = 1'b0;
    logic        o_busy, o_valid;
    logic [15:0] o_quotient, o_remainder;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lc4_divider_iter #(.W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    // Start a/b at edge E, then watch edges E+1..E+len. At edge E+inj_at either a
    // flush or a second start (a2/b2) is presented. Reports first valid edge and
    // number of valid pulses seen; busy_mid is o_busy just after E+1.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int len,
                          input int inj_at, input bit inj_flush,
                          input logic [15:0] a2, input logic [15:0] b2,
                          output bit got, output int lat, output int nvalid,
                          output logic busy_mid);
        @(negedge clk);
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start    = 1'b0;
        i_dividend = 16'hDEAD;
        i_divisor  = 16'hBEEF;
        got = 1'b0; lat = 0; nvalid = 0; busy_mid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (k == inj_at) begin
                if (inj_flush) i_flush = 1'b1;
                else begin
                    i_start = 1'b1; i_dividend = a2; i_divisor = b2;
                end
            end
            @(posedge clk);
            #1;
            i_flush = 1'b0;
            i_start = 1'b0;
            if (k == 1) busy_mid = o_busy;
            if (o_valid) begin
                nvalid++;
                if (!got) begin got = 1'b1; lat = k; end
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({o_busy, o_valid, o_quotient, o_remainder} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b valid=%b q=%h r=%h required all 0",
                     o_busy, o_valid, o_quotient, o_remainder);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        bit got; int lat, nv; logic bm;
        run_op(16'd100, 16'd7, 18, 0, 1'b0, 16'd0, 16'd0, got, lat, nv, bm);
        n_cmp++;
        if (!got || lat !== 16) begin
            n_bad++; $display("FAIL basic_latency: got valid=%b at %0d required 1 at 16", got, lat);
        end
        n_cmp++;
        if (nv !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d required 1", nv); end
        n_cmp++;
        if (o_quotient !== 16'd14 || o_remainder !== 16'd2) begin
            n_bad++; $display("FAIL basic_result: got q=%0d r=%0d required q=14 r=2",
                              o_quotient, o_remainder);
        end
        n_cmp++;
        if (bm !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_busy: got mid=%b after=%b required 1 then 0", bm, o_busy);
        end
    endtask

    task automatic test_edge_values;
        logic [15:0] va [4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'd1234};
        logic [15:0] vb [4] = '{16'h0001, 16'hFFFF, 16'h8001, 16'd0};
        logic [15:0] eq [4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
        logic [15:0] er [4] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000};
        bit got; int lat, nv; logic bm;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 17, 0, 1'b0, 16'd0, 16'd0, got, lat, nv, bm);
            n_cmp++;
            if (!got || lat !== 16 || o_quotient !== eq[i] || o_remainder !== er[i]) begin
                n_bad++;
                $display("FAIL edge_%0d %h/%h: got valid=%b lat=%0d q=%h r=%h required lat=16 q=%h r=%h",
                         i, va[i], vb[i], got, lat, o_quotient, o_remainder, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        bit got; int lat, nv; logic bm;
        run_op(16'd50, 16'd3, 24, 5, 1'b0, 16'd9, 16'd2, got, lat, nv, bm);
        n_cmp++;
        if (!got || lat !== 16 || nv !== 1) begin
            n_bad++; $display("FAIL start_ignored_timing: got lat=%0d pulses=%0d required 16/1", lat, nv);
        end
        n_cmp++;
        if (o_quotient !== 16'd16 || o_remainder !== 16'd2) begin
            n_bad++; $display("FAIL start_ignored_result: got q=%0d r=%0d required q=16 r=2",
                              o_quotient, o_remainder);
        end
    endtask

    task automatic test_flush;
        bit got; int lat, nv; logic bm;
        run_op(16'd77, 16'd5, 20, 8, 1'b1, 16'd0, 16'd0, got, lat, nv, bm);
        n_cmp++;
        if (nv !== 0 || o_busy !== 1'b0) begin
            n_bad++; $display("FAIL flush_novalid: got pulses=%0d busy=%b required 0/0", nv, o_busy);
        end
        n_cmp++;
        if (o_quotient !== 16'd16 || o_remainder !== 16'd2) begin
            n_bad++; $display("FAIL flush_hold: got q=%0d r=%0d required q=16 r=2",
                              o_quotient, o_remainder);
        end
        // Start and flush together in IDLE: nothing accepted.
        @(negedge clk);
        i_start = 1'b1; i_flush = 1'b1; i_dividend = 16'd9; i_divisor = 16'd2;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_flush = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++; $display("FAIL flush_wins: got busy=%b required 0", o_busy);
        end
        run_op(16'd77, 16'd5, 17, 0, 1'b0, 16'd0, 16'd0, got, lat, nv, bm);
        n_cmp++;
        if (!got || lat !== 16 || o_quotient !== 16'd15 || o_remainder !== 16'd2) begin
            n_bad++; $display("FAIL flush_restart: got lat=%0d q=%0d r=%0d required 16/15/2",
                              lat, o_quotient, o_remainder);
        end
    endtask

    task automatic test_async_reset;
        bit got; int lat, nv; logic bm;
        @(negedge clk);
        i_start = 1'b1; i_dividend = 16'd1000; i_divisor = 16'd3;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_busy, o_valid, o_quotient, o_remainder} !== 34'd0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b valid=%b q=%h r=%h required all 0",
                     o_busy, o_valid, o_quotient, o_remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        // Two operations at the 18-edge throughput.
        run_op(16'd300, 16'd17, 17, 0, 1'b0, 16'd0, 16'd0, got, lat, nv, bm);
        n_cmp++;
        if (!got || lat !== 16 || o_quotient !== 16'd17 || o_remainder !== 16'd11) begin
            n_bad++; $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d required 16/17/11",
                              lat, o_quotient, o_remainder);
        end
        run_op(16'd65000, 16'd255, 17, 0, 1'b0, 16'd0, 16'd0, got, lat, nv, bm);
        n_cmp++;
        if (!got || lat !== 16 || o_quotient !== 16'd254 || o_remainder !== 16'd230) begin
            n_bad++; $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d required 16/254/230",
                              lat, o_quotient, o_remainder);
        end
    endtask

    task automatic test_sweep;
        bit got; int lat, nv; logic bm;
        logic [15:0] a, b, eq, er;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 16));
            eq = (b == 16'd0) ? 16'd0 : a / b;
            er = (b == 16'd0) ? 16'd0 : a % b;
            run_op(a, b, 17, 0, 1'b0, 16'd0, 16'd0, got, lat, nv, bm);
            n_cmp++;
            if (!got || lat !== 16 || o_quotient !== eq || o_remainder !== er) begin
                n_bad++;
                $display("FAIL sweep %h/%h: got lat=%0d q=%h r=%h required lat=16 q=%h r=%h",
                         a, b, lat, o_quotient, o_remainder, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge_values();
        test_start_ignored();
        test_flush();
        test_async_reset();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
